// File: rtl/router_rx_bs_z.sv
// router_rx_bs_z: 3-bit serial frame receiver with a one-word WISHBONE-readable holding buffer
module router_rx_bs_z #(
    parameter int SYNC_STAGES  = 2,
    parameter int SAMPLE_PHASE = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cyc_i,
    input  logic         stb_i,
    input  logic         we_i,
    input  logic         cs_i,
    output logic         ack_o,
    output logic [127:0] dat_o,
    input  logic [2:0]   rxd,
    output logic         cts,
    output logic         full,
    output logic         frame_err,
    output logic         overrun
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t state, state_n;
    logic [SYNC_STAGES-1:0][2:0] sync;
    logic [2:0] rxs;
    logic [1:0] ph;
    logic [5:0] gc;
    logic [128:0] sr;
    logic samp, eval, good, load, req, req_q, rd_ev;

    assign ack_o = cyc_i & stb_i & cs_i;
    assign req   = ack_o & ~we_i;
    assign cts   = ~full;
    assign rxs   = sync[SYNC_STAGES-1];
    assign samp  = ph == 2'(SAMPLE_PHASE);
    assign good  = sr[128] && rxs == 3'b111;
    assign load  = eval && good && (!full || rd_ev);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync <= '1;
        end else begin
            sync[0] <= rxd;
            for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
        end
    end

    always_ff @(posedge clk_i) state <= rst_i ? IDLE : state_n;

    always_comb begin
        state_n = state;
        eval    = 1'b0;
        case (state)
            IDLE:  state_n = rxs == 3'b000 ? START : IDLE;
            START: state_n = samp && rxs != 3'b000 ? IDLE : ph == 2'd3 ? DATA : START;
            DATA:  state_n = samp && gc == 6'd43 ? STOP : DATA;
            STOP: begin
                eval    = samp && gc == 6'd44;
                state_n = eval ? IDLE : STOP;
            end
            default: state_n = IDLE;
        endcase
    end

    // ph/gc track the 4-cycle group timing; a new frame starts from ph=1 on the cycle after the start edge
    always_ff @(posedge clk_i) begin
        if (rst_i || state_n == IDLE) begin
            ph <= 2'd0;
            gc <= 6'd0;
        end else begin
            ph <= ph + 2'd1;
            if (ph == 2'd3) gc <= gc + 6'd1;
        end
    end

    always_ff @(posedge clk_i) if (state == DATA && samp) sr <= {rxs, sr[128:3]};

    // a read edge clears first, so a concurrent set of a flag wins and a good frame can reload
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_q     <= 1'b0;
            rd_ev     <= 1'b0;
            full      <= 1'b0;
            dat_o     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            req_q     <= req;
            rd_ev     <= req & ~req_q;
            full      <= load ? 1'b1 : rd_ev ? 1'b0 : full;
            dat_o     <= load ? sr[127:0] : dat_o;
            frame_err <= eval && !good ? 1'b1 : rd_ev ? 1'b0 : frame_err;
            overrun   <= eval && good && full && !rd_ev ? 1'b1 : rd_ev ? 1'b0 : overrun;
        end
    end
endmodule

// File: tb/tb_router_rx_bs_z.sv
// tb_router_rx_bs_z: directed and randomized frames against a frame-level model of the receive buffer
module tb_router_rx_bs_z;
    logic clk_i = 1'b0, rst_i = 1'b1;
    logic cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0, cs_i = 1'b0;
    logic [2:0] rxd = 3'b111;
    logic ack_o, cts, full, frame_err, overrun;
    logic [127:0] dat_o;
    int n_chk = 0, n_pass = 0;
    logic m_full = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;
    logic [127:0] m_dat = '0;
    localparam logic [127:0] D0 = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [127:0] D1 = {128{1'b1}};
    localparam logic [127:0] D2 = {16{8'hA5}};

    always #5 clk_i = ~clk_i;

    router_rx_bs_z #(.SYNC_STAGES(2), .SAMPLE_PHASE(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i), .cs_i(cs_i),
        .ack_o(ack_o), .dat_o(dat_o), .rxd(rxd), .cts(cts), .full(full),
        .frame_err(frame_err), .overrun(overrun)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".full"}, full, m_full);
        chk({tag, ".cts"}, cts, !m_full);
        chk({tag, ".dat_o"}, dat_o, m_dat);
        chk({tag, ".frame_err"}, frame_err, m_ferr);
        chk({tag, ".overrun"}, overrun, m_ovr);
    endtask

    // frame outcome from the receive rules: a read (if any) acts first, then the frame
    task automatic apply(input logic [127:0] d, input logic [2:0] stop, input logic rd);
        if (rd) begin
            m_full = 1'b0;
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
        end
        if (stop != 3'b111) m_ferr = 1'b1;
        else if (!m_full) begin
            m_full = 1'b1;
            m_dat  = d;
        end else m_ovr = 1'b1;
    endtask

    // drives the 45 groups (180 clocks); the first group follows the next clock edge
    task automatic send_frame(input logic [127:0] d, input logic [2:0] stop);
        logic [2:0] g;
        for (int k = 0; k < 45; k++) begin
            g = k == 0 ? 3'b000 : k == 44 ? stop : k == 43 ? {1'b1, d[127:126]} : d[3*k-1 -: 3];
            for (int c = 0; c < 4; c++) begin
                @(posedge clk_i);
                #1 rxd = g;
            end
        end
    endtask

    task automatic complete(input string tag, input logic [127:0] d, input logic [2:0] stop);
        @(posedge clk_i);
        #1 rxd = 3'b111;
        check_all({tag, ".pre"});
        @(posedge clk_i);
        #1 apply(d, stop, 1'b0);
        check_all({tag, ".post"});
    endtask

    task automatic bus_cycle(input string tag, input logic w);
        @(posedge clk_i);
        #1 {cyc_i, stb_i, cs_i, we_i} = {3'b111, w};
        #1 chk({tag, ".ack"}, ack_o, 1'b1);
        chk({tag, ".dat_during"}, dat_o, m_dat);
        @(posedge clk_i);
        #1 {cyc_i, stb_i, cs_i, we_i} = 4'b0000;
        @(posedge clk_i);
        #1 if (!w) begin
            m_full = 1'b0;
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
        end
        check_all(tag);
    endtask

    initial begin
        logic [127:0] d;
        logic [2:0] stop;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        check_all("reset");
        for (int i = 0; i < 500; i++) begin
            @(posedge clk_i);
            #1 chk("idle_stable", {full, cts, frame_err, overrun, |dat_o}, 5'b01000);
        end
        {cyc_i, stb_i, cs_i} = 3'b110;
        #1 chk("ack_no_cs", ack_o, 1'b0);
        {cyc_i, stb_i, cs_i} = 3'b000;
        send_frame(D0, 3'b111);
        complete("single", D0, 3'b111);
        bus_cycle("write_ignored", 1'b1);
        bus_cycle("read_clears", 1'b0);
        @(posedge clk_i);
        #1 rxd = 3'b000;
        repeat (2) @(posedge clk_i);
        #1 rxd = 3'b111;
        repeat (10) @(posedge clk_i);
        #1 check_all("false_start");
        send_frame(128'h1, 3'b111);
        complete("after_false", 128'h1, 3'b111);
        bus_cycle("read2", 1'b0);
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        send_frame(d, 3'b011);
        complete("frame_err", d, 3'b011);
        bus_cycle("read_ferr", 1'b0);
        send_frame(D1, 3'b111);
        send_frame(D2, 3'b111);
        apply(D1, 3'b111, 1'b0);
        complete("overrun", D2, 3'b111);
        bus_cycle("read_ovr", 1'b0);
        send_frame(D1, 3'b111);
        fork
            send_frame(D2, 3'b111);
            begin
                repeat (180) @(posedge clk_i);
                #1 {cyc_i, stb_i, cs_i} = 3'b111;
                #1 chk("coinc.ack", ack_o, 1'b1);
                @(posedge clk_i);
                #1 {cyc_i, stb_i, cs_i} = 3'b000;
            end
        join
        rxd = 3'b111;
        apply(D1, 3'b111, 1'b0);
        check_all("coinc.pre");
        @(posedge clk_i);
        #1 apply(D2, 3'b111, 1'b1);
        check_all("coinc.post");
        bus_cycle("read_coinc", 1'b0);
        for (int n = 0; n < 6; n++) begin
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            stop = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 6)) : 3'b111;
            send_frame(d, stop);
            complete("rand", d, stop);
            repeat ($urandom_range(0, 7)) @(posedge clk_i);
            if ($urandom_range(0, 1) == 1) bus_cycle("rand_read", 1'b0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
